// File: rtl/tone_pkg.sv
// Shared types and pitch constants for the piezo tone generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_e          - tone FSM states
//   NOTE_* / OCT_*   - key code and octave select encodings
//   NOTE_FREQ_CHZ    - equal-tempered pitches of the eight keys, in centihertz
//   half_period()    - cycles per half-period for a pitch at a given clock rate
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Key codes 1..8 are playable; anything else is a rest.
    localparam logic [3:0] NOTE_C4 = 4'd1;
    localparam logic [3:0] NOTE_C5 = 4'd8;

    localparam logic [1:0] OCT_DOWN = 2'd0;
    localparam logic [1:0] OCT_UP   = 2'd2;

    localparam int NUM_NOTES = 8;

    // C4 D4 E4 F4 G4 A4 B4 C5, in 1/100 Hz so the table stays integer.
    localparam int unsigned NOTE_FREQ_CHZ [NUM_NOTES] = '{
        32'd26163, 32'd29366, 32'd32963, 32'd34923,
        32'd39200, 32'd44000, 32'd49388, 32'd52325
    };

    // round(clk_hz / (2 * f)) with f given in centihertz. Elaboration-time only;
    // the 64-bit intermediate keeps clk_hz * 100 from overflowing.
    function automatic int unsigned half_period(input int unsigned clk_hz,
                                                input int unsigned f_chz);
        longint unsigned num;
        longint unsigned den;
        num = longint'(clk_hz) * 64'd100 + 64'(f_chz);
        den = 64'(f_chz) * 64'd2;
        return 32'(num / den);
    endfunction

endpackage

// File: rtl/tone_rom.sv
// Key/octave to half-period lookup: base table entry shifted by octave.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the inputs.
//
// Ports:
//   iNote       [3:0]      key code, 1..8 playable, others are rests
//   iOctave     [1:0]      0 = down, 2 = up, 1/3 = as listed
//   oHalfPeriod [HP_W-1:0] cycles per buzzer level for the selection
//   oValid                 1 when iNote names a playable key
module tone_rom
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 1000000,
    parameter int          HP_W   = 12
) (
    input  logic [3:0]      iNote,
    input  logic [1:0]      iOctave,
    output logic [HP_W-1:0] oHalfPeriod,
    output logic            oValid
);

    // Base half-periods for the configured clock, built at elaboration so no
    // divider is ever synthesised.
    localparam int unsigned HP_TAB [NUM_NOTES] = '{
        half_period(CLK_HZ, NOTE_FREQ_CHZ[0]),
        half_period(CLK_HZ, NOTE_FREQ_CHZ[1]),
        half_period(CLK_HZ, NOTE_FREQ_CHZ[2]),
        half_period(CLK_HZ, NOTE_FREQ_CHZ[3]),
        half_period(CLK_HZ, NOTE_FREQ_CHZ[4]),
        half_period(CLK_HZ, NOTE_FREQ_CHZ[5]),
        half_period(CLK_HZ, NOTE_FREQ_CHZ[6]),
        half_period(CLK_HZ, NOTE_FREQ_CHZ[7])
    };

    logic [2:0]      tab_idx;
    logic [HP_W-1:0] base_hp;

    always_comb begin
        tab_idx = 3'(iNote - NOTE_C4);
        base_hp = '0;
        oValid  = 1'b0;
        if (iNote >= NOTE_C4 && iNote <= NOTE_C5) begin
            oValid  = 1'b1;
            base_hp = HP_W'(HP_TAB[tab_idx]);
        end
    end

    // Octave down doubles the half-period; octave up halves it, truncating
    // (C4 up becomes 955, not 956).
    always_comb begin
        case (iOctave)
            OCT_DOWN: oHalfPeriod = base_hp << 1;
            OCT_UP:   oHalfPeriod = base_hp >> 1;
            default:  oHalfPeriod = base_hp;
        endcase
    end

endmodule

// File: rtl/tone_generator.sv
// Glitch-free square-wave driver for the piano buzzer; pitch changes only on level boundaries.
// Latency: one cycle from a valid gate to oBuzzer high; release completes within one half-period.
// Backpressure: none; free-running output, the gate may drop or return at any time.
//
// Ports:
//   iClk     system clock, rising edge
//   iReset   synchronous active-high reset, overrides everything
//   iRing    play gate from the note-length counter
//   iNote    key code (1..8 playable, others rest)
//   iOctave  octave select (0 down, 1/3 normal, 2 up)
//   oBuzzer  registered square wave, idles low
//   oBusy    registered, high whenever a tone is sounding or draining
module tone_generator
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 1000000,
    parameter int          HP_W   = 12
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iRing,
    input  logic [3:0] iNote,
    input  logic [1:0] iOctave,
    output logic       oBuzzer,
    output logic       oBusy
);

    state_e          state_q, state_d;
    logic [HP_W-1:0] cnt_q,   cnt_d;
    logic [HP_W-1:0] hp_q,    hp_d;
    logic            buzz_q,  buzz_d;
    logic            busy_q,  busy_d;

    logic [HP_W-1:0] sel_hp;
    logic            sel_vld;
    logic            play_vld;
    logic            boundary;

    tone_rom #(
        .CLK_HZ (CLK_HZ),
        .HP_W   (HP_W)
    ) u_rom (
        .iNote       (iNote),
        .iOctave     (iOctave),
        .oHalfPeriod (sel_hp),
        .oValid      (sel_vld)
    );

    assign play_vld = iRing & sel_vld;

    // Last cycle of the current level. hp_q is only meaningful outside IDLE,
    // which is the only place this is consulted.
    assign boundary = (cnt_q == hp_q - HP_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        buzz_d  = buzz_q;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                buzz_d = 1'b0;
                if (play_vld) begin
                    state_d = PLAY;
                    buzz_d  = 1'b1;
                    hp_d    = sel_hp;
                end
            end

            PLAY: begin
                if (play_vld) begin
                    if (boundary) begin
                        // Only place a new pitch is picked up.
                        buzz_d = ~buzz_q;
                        cnt_d  = '0;
                        hp_d   = sel_hp;
                    end else begin
                        cnt_d = cnt_q + HP_W'(1);
                    end
                end else if (buzz_q) begin
                    if (boundary) begin
                        // High level ends on this very edge: fall straight to idle.
                        buzz_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        // Let the high level run its full length before stopping.
                        cnt_d   = cnt_q + HP_W'(1);
                        state_d = DRAIN;
                    end
                end else begin
                    // Already low: stopping now cannot shorten a pulse.
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            DRAIN: begin
                // Pitch inputs are not consulted until the level finishes.
                if (boundary) begin
                    buzz_d = 1'b0;
                    cnt_d  = '0;
                    if (play_vld) begin
                        // Gate came back exactly at the edge: carry on playing
                        // rather than idle for a cycle and emit a runt low.
                        state_d = PLAY;
                        hp_d    = sel_hp;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // A returning gate resumes play without restarting the phase.
                    cnt_d = cnt_q + HP_W'(1);
                    if (play_vld) begin
                        state_d = PLAY;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                buzz_d  = 1'b0;
            end
        endcase
    end

    // Registered so oBusy falls on the same edge as the final buzzer fall.
    always_comb begin
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hp_q    <= '0;
            buzz_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            buzz_q  <= buzz_d;
            busy_q  <= busy_d;
        end
    end

    assign oBuzzer = buzz_q;
    assign oBusy   = busy_q;

endmodule
